// File: rtl/uart_pkg.sv
// Shared constants, state encoding and frame payload for the UART register responder.
// UART_RESP_CKSUM_EN adds the checksum-collection state.
package uart_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] ST_IDLE     = 3'd0;
  localparam logic [StateW-1:0] ST_GET_ADDR = 3'd1;
  localparam logic [StateW-1:0] ST_GET_DATA = 3'd2;
  localparam logic [StateW-1:0] ST_EXEC     = 3'd3;
  localparam logic [StateW-1:0] ST_SEND     = 3'd4;
  localparam logic [StateW-1:0] ST_WAIT_HI  = 3'd5;
  localparam logic [StateW-1:0] ST_WAIT_LO  = 3'd6;
`ifdef UART_RESP_CKSUM_EN
  localparam logic [StateW-1:0] ST_GET_CKSUM = 3'd7;
`endif

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
  } frame_t;

  // Inter-byte timeout in clock cycles: byte times * 10 bits * cycles per bit.
  function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                 input int unsigned baud_rate,
                                                 input int unsigned timeout_bytes);
    return timeout_bytes * 10 * (clk_freq / baud_rate);
  endfunction

endpackage

// File: rtl/uart_resp_timeout.sv
// Loadable down-counter: clear reloads the full count, enable counts down,
// expire_c flags the cycle in which the count reaches zero.
module uart_resp_timeout #(
  parameter int unsigned Cycles = 9360
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CntW'(Cycles);
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CntW'(1);
    end
  end

  // A clear in the same cycle always beats expiry.
  assign expire_c = enable && !clear && (cnt == CntW'(1));

endmodule

// File: rtl/uart_reg_responder.sv
// UART read/write command responder driving an 8-bit register file.
// Define UART_RESP_CKSUM_EN for XOR-checksummed frames and complemented echo responses.
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int unsigned ClkFreq      = 27_000_000,
  parameter int unsigned BaudRate     = 115_200,
  parameter int unsigned NumRegs      = 16,
  parameter int unsigned TimeoutBytes = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx_valid,
  input  logic [7:0]             i_rx_byte,
  output logic                   o_tx_enable,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_busy,
  output logic [8*NumRegs-1:0]   o_regs,
  output logic [7:0]             o_err_cnt
);

  localparam int unsigned AddrW         = $clog2(NumRegs);
  localparam int unsigned TimeoutCycles = timeout_cycles(ClkFreq, BaudRate, TimeoutBytes);

`ifdef UART_RESP_CKSUM_EN
  localparam logic [StateW-1:0] ST_AFTER_FRAME = ST_GET_CKSUM;
`else
  localparam logic [StateW-1:0] ST_AFTER_FRAME = ST_EXEC;
`endif

  logic [StateW-1:0] state, state_d;
  frame_t            frame, frame_d;
  logic [7:0]        rsp, rsp_d;
  logic              tx_enable_d;
  logic [7:0]        tx_data_d;
  logic [7:0]        err_cnt_d;
  logic [8:0]        err_sum_c;
  logic [1:0]        err_add_c;
  logic              reg_we_c;
  logic [AddrW-1:0]  reg_idx_c;
  logic              addr_bad_c;
  logic              cmd_ok_c;
  logic              ck_bad_c;
  logic              more_c;
  logic              to_enable_c;
  logic              to_expire_c;
  logic [7:0]        regs [NumRegs];

  assign reg_idx_c  = frame.addr[AddrW-1:0];
  assign addr_bad_c = 32'(frame.addr) >= NumRegs;
  assign cmd_ok_c   = (i_rx_byte == CMD_WR) || (i_rx_byte == CMD_RD);

  uart_resp_timeout #(
    .Cycles (TimeoutCycles)
  ) u_timeout (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear    (i_rx_valid),
    .enable   (to_enable_c),
    .expire_c (to_expire_c)
  );

`ifdef UART_RESP_CKSUM_EN
  logic [7:0] ck, ck_d;
  logic       second, second_d;

  // Running XOR over the frame; a good frame including its checksum byte folds to zero.
  always_comb begin
    ck_d     = ck;
    second_d = second;
    if (i_rx_valid) begin
      if (state == ST_IDLE) begin
        ck_d = i_rx_byte;
      end else if ((state == ST_GET_ADDR) || (state == ST_GET_DATA) || (state == ST_GET_CKSUM)) begin
        ck_d = ck ^ i_rx_byte;
      end
    end
    if ((state == ST_EXEC) || ((state == ST_IDLE) && i_rx_valid && !cmd_ok_c)) begin
      second_d = 1'b1;
    end else if ((state == ST_WAIT_LO) && !i_tx_busy) begin
      second_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ck     <= '0;
      second <= 1'b0;
    end else begin
      ck     <= ck_d;
      second <= second_d;
    end
  end

  assign ck_bad_c    = ck != 8'h00;
  assign more_c      = second;
  assign to_enable_c = (state == ST_GET_ADDR) || (state == ST_GET_DATA) || (state == ST_GET_CKSUM);
`else
  assign ck_bad_c    = 1'b0;
  assign more_c      = 1'b0;
  assign to_enable_c = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      frame       <= '0;
      rsp         <= '0;
      o_tx_enable <= 1'b0;
      o_tx_data   <= '0;
      o_err_cnt   <= '0;
    end else begin
      state       <= state_d;
      frame       <= frame_d;
      rsp         <= rsp_d;
      o_tx_enable <= tx_enable_d;
      o_tx_data   <= tx_data_d;
      o_err_cnt   <= err_cnt_d;
    end
  end

  // Next-state, response selection and error accounting.
  always_comb begin
    state_d     = state;
    frame_d     = frame;
    rsp_d       = rsp;
    tx_enable_d = 1'b0;
    tx_data_d   = o_tx_data;
    err_add_c   = 2'd0;
    reg_we_c    = 1'b0;
    err_sum_c   = '0;
    err_cnt_d   = o_err_cnt;

    case (state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (cmd_ok_c) begin
            frame_d.cmd = i_rx_byte;
            state_d     = ST_GET_ADDR;
          end else begin
            rsp_d     = RSP_NAK;
            err_add_c = 2'd1;
            state_d   = ST_SEND;
          end
        end
      end
      ST_GET_ADDR: begin
        if (i_rx_valid) begin
          frame_d.addr = i_rx_byte;
          state_d      = (frame.cmd == CMD_WR) ? ST_GET_DATA : ST_AFTER_FRAME;
        end else if (to_expire_c) begin
          err_add_c = 2'd1;
          state_d   = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (i_rx_valid) begin
          frame_d.data = i_rx_byte;
          state_d      = ST_AFTER_FRAME;
        end else if (to_expire_c) begin
          err_add_c = 2'd1;
          state_d   = ST_IDLE;
        end
      end
`ifdef UART_RESP_CKSUM_EN
      ST_GET_CKSUM: begin
        if (i_rx_valid) begin
          state_d = ST_EXEC;
        end else if (to_expire_c) begin
          err_add_c = 2'd1;
          state_d   = ST_IDLE;
        end
      end
`endif
      ST_EXEC: begin
        if (addr_bad_c || ck_bad_c) begin
          rsp_d     = RSP_NAK;
          err_add_c = 2'd1;
        end else if (frame.cmd == CMD_WR) begin
          reg_we_c = 1'b1;
          rsp_d    = RSP_ACK;
        end else begin
          rsp_d = regs[reg_idx_c];
        end
        if (i_rx_valid) begin
          err_add_c = err_add_c + 2'd1;
        end
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          tx_enable_d = 1'b1;
          tx_data_d   = rsp;
          state_d     = ST_WAIT_HI;
        end
        if (i_rx_valid) begin
          err_add_c = 2'd1;
        end
      end
      ST_WAIT_HI: begin
        if (i_tx_busy) begin
          state_d = ST_WAIT_LO;
        end
        if (i_rx_valid) begin
          err_add_c = 2'd1;
        end
      end
      ST_WAIT_LO: begin
        if (!i_tx_busy) begin
          if (more_c) begin
            rsp_d   = rsp ^ 8'hFF;
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
        if (i_rx_valid) begin
          err_add_c = 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_sum_c = 9'(o_err_cnt) + 9'(err_add_c);
    err_cnt_d = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];
  end

  // Register file; a write lands on the edge leaving EXEC.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(NumRegs); k++) begin
        regs[k] <= '0;
      end
    end else if (reg_we_c) begin
      regs[reg_idx_c] <= frame.data;
    end
  end

  for (genvar g = 0; g < int'(NumRegs); g++) begin : g_regs_out
    assign o_regs[8*g +: 8] = regs[g];
  end

endmodule
